// File: rtl/rs_alu_station.sv
// Reservation station for one ALU pipe: holds dispatched ops, snoops the CDB for
// missing operands, exposes a ready vector and issues the granted entry into a one-cycle issue register.
module rs_alu_station #(
  parameter int RS_ENT_NUM = 2,
  parameter int RS_ENT_SEL = 1,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 6,
  parameter int OP_W       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_dsp_vld,
  input  logic [OP_W-1:0]       i_dsp_op,
  input  logic                  i_dsp_src1_rdy,
  input  logic [DATA_W-1:0]     i_dsp_src1_data,
  input  logic [TAG_W-1:0]      i_dsp_src1_tag,
  input  logic                  i_dsp_src2_rdy,
  input  logic [DATA_W-1:0]     i_dsp_src2_data,
  input  logic [TAG_W-1:0]      i_dsp_src2_tag,
  input  logic [TAG_W-1:0]      i_dsp_dst_tag,
  output logic                  o_full,
  input  logic                  i_cdb_vld,
  input  logic [TAG_W-1:0]      i_cdb_tag,
  input  logic [DATA_W-1:0]     i_cdb_data,
  output logic [RS_ENT_NUM-1:0] o_rdy_vec,
  input  logic                  i_sel_vld,
  input  logic [RS_ENT_SEL-1:0] i_sel,
  output logic                  o_iss_vld,
  output logic [OP_W-1:0]       o_iss_op,
  output logic [DATA_W-1:0]     o_iss_src1,
  output logic [DATA_W-1:0]     o_iss_src2,
  output logic [TAG_W-1:0]      o_iss_dst_tag
);

  typedef struct packed {
    logic              vld;
    logic [OP_W-1:0]   op;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_data;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_data;
    logic [TAG_W-1:0]  s2_tag;
    logic [TAG_W-1:0]  dst_tag;
  } ent_t;

  ent_t ent_q [RS_ENT_NUM];
  ent_t ent_d [RS_ENT_NUM];

  logic [RS_ENT_NUM-1:0] vld_vec;
  logic [RS_ENT_NUM-1:0] rdy_vec;
  logic [RS_ENT_NUM-1:0] free_oh;
  logic [RS_ENT_NUM-1:0] iss_oh;
  ent_t                  sel_ent;
  logic                  dsp_acc;
  logic                  iss_fire;
  logic                  s1_byp;
  logic                  s2_byp;

  logic                  iss_vld_q, iss_vld_d;
  logic [OP_W-1:0]       iss_op_q, iss_op_d;
  logic [DATA_W-1:0]     iss_src1_q, iss_src1_d;
  logic [DATA_W-1:0]     iss_src2_q, iss_src2_d;
  logic [TAG_W-1:0]      iss_dst_q, iss_dst_d;

  always_comb begin
    for (int k = 0; k < RS_ENT_NUM; k++) begin
      vld_vec[k] = ent_q[k].vld;
      rdy_vec[k] = ent_q[k].vld & ent_q[k].s1_rdy & ent_q[k].s2_rdy;
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    free_oh = '0;
    for (int k = RS_ENT_NUM - 1; k >= 0; k--) begin
      if (!vld_vec[k]) begin
        free_oh    = '0;
        free_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    iss_oh  = '0;
    sel_ent = '0;
    for (int k = 0; k < RS_ENT_NUM; k++) begin
      if (i_sel_vld && (i_sel == RS_ENT_SEL'(k)) && rdy_vec[k]) begin
        iss_oh[k] = 1'b1;
        sel_ent   = ent_q[k];
      end
    end
  end

  assign o_full   = &vld_vec;
  assign dsp_acc  = i_dsp_vld & ~o_full;
  assign iss_fire = |iss_oh;
  assign s1_byp   = ~i_dsp_src1_rdy & i_cdb_vld & (i_dsp_src1_tag == i_cdb_tag);
  assign s2_byp   = ~i_dsp_src2_rdy & i_cdb_vld & (i_dsp_src2_tag == i_cdb_tag);

  always_comb begin
    for (int k = 0; k < RS_ENT_NUM; k++) begin
      ent_d[k] = ent_q[k];
      if (i_flush) begin
        ent_d[k].vld = 1'b0;
      end else if (dsp_acc && free_oh[k]) begin
        ent_d[k].vld     = 1'b1;
        ent_d[k].op      = i_dsp_op;
        ent_d[k].s1_rdy  = i_dsp_src1_rdy | s1_byp;
        ent_d[k].s1_data = s1_byp ? i_cdb_data : i_dsp_src1_data;
        ent_d[k].s1_tag  = i_dsp_src1_tag;
        ent_d[k].s2_rdy  = i_dsp_src2_rdy | s2_byp;
        ent_d[k].s2_data = s2_byp ? i_cdb_data : i_dsp_src2_data;
        ent_d[k].s2_tag  = i_dsp_src2_tag;
        ent_d[k].dst_tag = i_dsp_dst_tag;
      end else if (ent_q[k].vld) begin
        if (iss_oh[k]) ent_d[k].vld = 1'b0;
        if (!ent_q[k].s1_rdy && i_cdb_vld && (ent_q[k].s1_tag == i_cdb_tag)) begin
          ent_d[k].s1_rdy  = 1'b1;
          ent_d[k].s1_data = i_cdb_data;
        end
        if (!ent_q[k].s2_rdy && i_cdb_vld && (ent_q[k].s2_tag == i_cdb_tag)) begin
          ent_d[k].s2_rdy  = 1'b1;
          ent_d[k].s2_data = i_cdb_data;
        end
      end
    end
  end

  // Payload only reloads on a real grant; valid is the sole qualifier downstream.
  always_comb begin
    iss_vld_d  = iss_fire & ~i_flush;
    iss_op_d   = iss_op_q;
    iss_src1_d = iss_src1_q;
    iss_src2_d = iss_src2_q;
    iss_dst_d  = iss_dst_q;
    if (iss_fire && !i_flush) begin
      iss_op_d   = sel_ent.op;
      iss_src1_d = sel_ent.s1_data;
      iss_src2_d = sel_ent.s2_data;
      iss_dst_d  = sel_ent.dst_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < RS_ENT_NUM; k++) ent_q[k] <= '0;
      iss_vld_q  <= 1'b0;
      iss_op_q   <= '0;
      iss_src1_q <= '0;
      iss_src2_q <= '0;
      iss_dst_q  <= '0;
    end else begin
      for (int k = 0; k < RS_ENT_NUM; k++) ent_q[k] <= ent_d[k];
      iss_vld_q  <= iss_vld_d;
      iss_op_q   <= iss_op_d;
      iss_src1_q <= iss_src1_d;
      iss_src2_q <= iss_src2_d;
      iss_dst_q  <= iss_dst_d;
    end
  end

  assign o_rdy_vec     = rdy_vec;
  assign o_iss_vld     = iss_vld_q;
  assign o_iss_op      = iss_op_q;
  assign o_iss_src1    = iss_src1_q;
  assign o_iss_src2    = iss_src2_q;
  assign o_iss_dst_tag = iss_dst_q;

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: directed scenarios plus random traffic checked
// against an entry-table reference model.
module tb_rs_alu_station;
  localparam int N = 2, SW = 1, DW = 32, TW = 6, OW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          dsp_vld = 1'b0;
  logic [OW-1:0] dsp_op = '0;
  logic          s1_rdy = 1'b0, s2_rdy = 1'b0;
  logic [DW-1:0] s1_data = '0, s2_data = '0;
  logic [TW-1:0] s1_tag = '0, s2_tag = '0, dst_tag = '0;
  logic          cdb_vld = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic          sel_vld = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          full, iss_vld;
  logic [N-1:0]  rdy_vec;
  logic [OW-1:0] iss_op;
  logic [DW-1:0] iss_src1, iss_src2;
  logic [TW-1:0] iss_dst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_alu_station #(.RS_ENT_NUM(N), .RS_ENT_SEL(SW), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_dsp_vld(dsp_vld), .i_dsp_op(dsp_op),
    .i_dsp_src1_rdy(s1_rdy), .i_dsp_src1_data(s1_data), .i_dsp_src1_tag(s1_tag),
    .i_dsp_src2_rdy(s2_rdy), .i_dsp_src2_data(s2_data), .i_dsp_src2_tag(s2_tag),
    .i_dsp_dst_tag(dst_tag), .o_full(full),
    .i_cdb_vld(cdb_vld), .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data),
    .o_rdy_vec(rdy_vec), .i_sel_vld(sel_vld), .i_sel(sel),
    .o_iss_vld(iss_vld), .o_iss_op(iss_op), .o_iss_src1(iss_src1),
    .o_iss_src2(iss_src2), .o_iss_dst_tag(iss_dst)
  );

  // Reference model: a table of waiting instructions and the last issued one.
  logic          m_vld [N];
  logic [OW-1:0] m_op  [N];
  logic          m_r1  [N], m_r2 [N];
  logic [DW-1:0] m_d1  [N], m_d2 [N];
  logic [TW-1:0] m_t1  [N], m_t2 [N], m_dst [N];
  logic          m_iss_vld;
  logic [OW-1:0] m_iss_op;
  logic [DW-1:0] m_iss_s1, m_iss_s2;
  logic [TW-1:0] m_iss_dst;

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = m_vld[k] && m_r1[k] && m_r2[k];
    return v;
  endfunction

  function automatic logic exp_full();
    int cnt = 0;
    for (int k = 0; k < N; k++) if (m_vld[k]) cnt++;
    return cnt == N;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_vld[k] = 0; m_op[k] = '0; m_r1[k] = 0; m_r2[k] = 0; m_d1[k] = '0;
      m_d2[k] = '0; m_t1[k] = '0; m_t2[k] = '0; m_dst[k] = '0;
    end
    m_iss_vld = 0; m_iss_op = '0; m_iss_s1 = '0; m_iss_s2 = '0; m_iss_dst = '0;
  endtask

  // Apply one clock of the behavioural rules, then let the DUT take the same edge.
  task automatic step();
    logic [N-1:0] rdy_now;
    logic         was_full;
    int           slot;
    rdy_now  = exp_rdy();
    was_full = exp_full();
    slot     = -1;
    for (int k = N - 1; k >= 0; k--) if (!m_vld[k]) slot = k;
    if (flush) begin
      for (int k = 0; k < N; k++) m_vld[k] = 0;
      m_iss_vld = 0;
    end else begin
      m_iss_vld = sel_vld && rdy_now[sel];
      if (m_iss_vld) begin
        m_iss_op = m_op[sel]; m_iss_s1 = m_d1[sel]; m_iss_s2 = m_d2[sel]; m_iss_dst = m_dst[sel];
        m_vld[sel] = 0;
      end
      for (int k = 0; k < N; k++) begin
        if (cdb_vld && !m_r1[k] && m_t1[k] == cdb_tag) begin m_r1[k] = 1; m_d1[k] = cdb_data; end
        if (cdb_vld && !m_r2[k] && m_t2[k] == cdb_tag) begin m_r2[k] = 1; m_d2[k] = cdb_data; end
      end
      if (dsp_vld && !was_full) begin
        m_vld[slot] = 1; m_op[slot] = dsp_op; m_dst[slot] = dst_tag;
        m_t1[slot] = s1_tag; m_t2[slot] = s2_tag;
        m_r1[slot] = s1_rdy || (cdb_vld && s1_tag == cdb_tag);
        m_d1[slot] = (!s1_rdy && cdb_vld && s1_tag == cdb_tag) ? cdb_data : s1_data;
        m_r2[slot] = s2_rdy || (cdb_vld && s2_tag == cdb_tag);
        m_d2[slot] = (!s2_rdy && cdb_vld && s2_tag == cdb_tag) ? cdb_data : s2_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_dsp(input logic [OW-1:0] op, input logic r1, input logic [DW-1:0] d1,
                         input logic [TW-1:0] t1, input logic r2, input logic [DW-1:0] d2,
                         input logic [TW-1:0] t2, input logic [TW-1:0] dst);
    dsp_vld = 1; dsp_op = op; s1_rdy = r1; s1_data = d1; s1_tag = t1;
    s2_rdy = r2; s2_data = d2; s2_tag = t2; dst_tag = dst;
  endtask

  task automatic idle();
    dsp_vld = 0; cdb_vld = 0; sel_vld = 0; flush = 0;
  endtask

  task automatic clear();
    idle(); flush = 1; step(); flush = 0;
  endtask

  task automatic test_reset();
    checks++; if ({full, rdy_vec, iss_vld, iss_op, iss_src1, iss_src2, iss_dst} !== '0) begin
      errors++; $display("FAIL reset_hold outs=%h required 0", {full, rdy_vec, iss_vld, iss_op, iss_src1, iss_src2, iss_dst});
    end
    @(negedge clk); rst_n = 1; model_reset();
    set_dsp(4'h6, 1, 32'h1234, 0, 1, 32'h5678, 0, 6'd3); step();
    set_dsp(4'h2, 1, 32'h1, 0, 1, 32'h2, 0, 6'd4); step();
    dsp_vld = 0; sel_vld = 1; sel = 0; step(); sel_vld = 0;
    checks++; if (iss_vld !== 1'b1 || iss_op !== 4'h6) begin
      errors++; $display("FAIL reset_pre vld=%b op=%h required 1/6", iss_vld, iss_op);
    end
    #2 rst_n = 0; #1;
    checks++; if ({full, rdy_vec, iss_vld, iss_op, iss_src1, iss_src2, iss_dst} !== '0) begin
      errors++; $display("FAIL reset_async outs=%h required 0", {full, rdy_vec, iss_vld, iss_op, iss_src1, iss_src2, iss_dst});
    end
    #1 rst_n = 1; model_reset(); #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b required 0", full); end
  endtask

  task automatic test_ready_dispatch();
    clear();
    set_dsp(4'd3, 1, 32'h11, 0, 1, 32'h22, 0, 6'd5); step(); dsp_vld = 0;
    checks++; if (rdy_vec !== 2'b01 || iss_vld !== 0) begin
      errors++; $display("FAIL rd_rdy rdy=%b iss=%b required 01/0", rdy_vec, iss_vld);
    end
    sel_vld = 1; sel = 0; step(); sel_vld = 0;
    checks++; if ({iss_vld, iss_op, iss_src1, iss_src2, iss_dst} !== {1'b1, 4'd3, 32'h11, 32'h22, 6'd5}) begin
      errors++; $display("FAIL rd_issue got %b %h %h %h %h required 1 3 11 22 05", iss_vld, iss_op, iss_src1, iss_src2, iss_dst);
    end
    step();
    checks++; if (iss_vld !== 0 || rdy_vec !== 0) begin
      errors++; $display("FAIL rd_single vld=%b rdy=%b required 0/00", iss_vld, rdy_vec);
    end
  endtask

  task automatic test_wakeup();
    clear();
    set_dsp(4'd4, 0, 32'h0, 6'd9, 1, 32'h33, 0, 6'd6); step(); dsp_vld = 0;
    checks++; if (rdy_vec !== 2'b00) begin errors++; $display("FAIL wk_wait rdy=%b required 00", rdy_vec); end
    cdb_vld = 1; cdb_tag = 6'd8; cdb_data = 32'h55; sel_vld = 1; sel = 0; step();
    checks++; if (rdy_vec !== 2'b00 || iss_vld !== 0) begin
      errors++; $display("FAIL wk_wrongtag rdy=%b iss=%b required 00/0", rdy_vec, iss_vld);
    end
    cdb_tag = 6'd9; cdb_data = 32'hAB; step(); cdb_vld = 0;
    checks++; if (rdy_vec !== 2'b01 || iss_vld !== 0) begin
      errors++; $display("FAIL wk_rdy rdy=%b iss=%b required 01/0", rdy_vec, iss_vld);
    end
    step(); sel_vld = 0;
    checks++; if (iss_vld !== 1 || iss_src1 !== 32'hAB || iss_src2 !== 32'h33) begin
      errors++; $display("FAIL wk_issue vld=%b s1=%h s2=%h required 1/ab/33", iss_vld, iss_src1, iss_src2);
    end
  endtask

  task automatic test_full_reuse();
    clear();
    set_dsp(4'd1, 1, 32'h1, 0, 1, 32'h2, 0, 6'd1); step();
    set_dsp(4'd2, 1, 32'h3, 0, 1, 32'h4, 0, 6'd2); step();
    checks++; if (full !== 1 || rdy_vec !== 2'b11) begin
      errors++; $display("FAIL fr_full full=%b rdy=%b required 1/11", full, rdy_vec);
    end
    set_dsp(4'd7, 1, 32'h5, 0, 1, 32'h6, 0, 6'd7); step(); dsp_vld = 0;
    sel_vld = 1; sel = 1; step(); sel_vld = 0;
    checks++; if (full !== 0 || iss_op !== 4'd2 || rdy_vec !== 2'b01) begin
      errors++; $display("FAIL fr_drop full=%b op=%h rdy=%b required 0/2/01", full, iss_op, rdy_vec);
    end
    set_dsp(4'd9, 1, 32'h7, 0, 1, 32'h8, 0, 6'd9); step(); dsp_vld = 0;
    sel_vld = 1; sel = 1; step();
    checks++; if (iss_vld !== 1 || iss_op !== 4'd9) begin
      errors++; $display("FAIL fr_reuse vld=%b op=%h required 1/9", iss_vld, iss_op);
    end
    sel = 0; step(); sel_vld = 0;
    checks++; if (iss_op !== 4'd1 || full !== 0 || rdy_vec !== 0) begin
      errors++; $display("FAIL fr_third op=%h full=%b rdy=%b required 1/0/00", iss_op, full, rdy_vec);
    end
  endtask

  task automatic test_bypass();
    clear();
    set_dsp(4'd5, 1, 32'h1, 0, 0, 32'h0, 6'd4, 6'd10);
    cdb_vld = 1; cdb_tag = 6'd4; cdb_data = 32'h77; step(); idle();
    checks++; if (rdy_vec !== 2'b01) begin errors++; $display("FAIL byp_rdy rdy=%b required 01", rdy_vec); end
    sel_vld = 1; sel = 0; step(); sel_vld = 0;
    checks++; if (iss_vld !== 1 || iss_src2 !== 32'h77 || iss_dst !== 6'd10) begin
      errors++; $display("FAIL byp_issue vld=%b s2=%h dst=%h required 1/77/0a", iss_vld, iss_src2, iss_dst);
    end
  endtask

  task automatic test_flush();
    clear();
    set_dsp(4'd1, 1, 32'h1, 0, 1, 32'h2, 0, 6'd1); step();
    set_dsp(4'd2, 1, 32'h3, 0, 1, 32'h4, 0, 6'd2); step();
    sel_vld = 1; sel = 0; flush = 1; step(); flush = 0; sel_vld = 0;
    checks++; if (rdy_vec !== 0 || iss_vld !== 0 || full !== 0) begin
      errors++; $display("FAIL fl_kill rdy=%b iss=%b full=%b required 00/0/0", rdy_vec, iss_vld, full);
    end
    set_dsp(4'd3, 1, 32'h5, 0, 1, 32'h6, 0, 6'd3); flush = 1; step(); idle(); step();
    checks++; if (rdy_vec !== 0 || full !== 0) begin
      errors++; $display("FAIL fl_dsp rdy=%b full=%b required 00/0", rdy_vec, full);
    end
  endtask

  task automatic test_back_to_back();
    clear();
    set_dsp(4'hA, 1, 32'hA1, 0, 1, 32'hA2, 0, 6'd11); step();
    set_dsp(4'hB, 1, 32'hB1, 0, 1, 32'hB2, 0, 6'd12); sel_vld = 1; sel = 0; step(); dsp_vld = 0;
    checks++; if (iss_vld !== 1 || iss_op !== 4'hA || rdy_vec !== 2'b10) begin
      errors++; $display("FAIL b2b_first vld=%b op=%h rdy=%b required 1/a/10", iss_vld, iss_op, rdy_vec);
    end
    sel = 1; step(); sel_vld = 0;
    checks++; if (iss_vld !== 1 || iss_op !== 4'hB || iss_src1 !== 32'hB1) begin
      errors++; $display("FAIL b2b_second vld=%b op=%h s1=%h required 1/b/b1", iss_vld, iss_op, iss_src1);
    end
  endtask

  task automatic test_random();
    clear();
    for (int c = 0; c < 600; c++) begin
      flush    = ($urandom_range(0, 31) == 0);
      dsp_vld  = $urandom_range(0, 9) < 6;
      dsp_op   = OW'($urandom); dst_tag = TW'($urandom);
      s1_rdy   = $urandom_range(0, 1) == 1; s1_data = $urandom; s1_tag = TW'($urandom_range(0, 3));
      s2_rdy   = $urandom_range(0, 1) == 1; s2_data = $urandom; s2_tag = TW'($urandom_range(0, 3));
      cdb_vld  = $urandom_range(0, 1) == 1; cdb_tag = TW'($urandom_range(0, 3)); cdb_data = $urandom;
      sel_vld  = $urandom_range(0, 1) == 1; sel = SW'($urandom_range(0, N - 1));
      step();
      checks++; if (full !== exp_full() || rdy_vec !== exp_rdy()) begin
        errors++; $display("FAIL rnd_state cyc=%0d full=%b rdy=%b required %b/%b", c, full, rdy_vec, exp_full(), exp_rdy());
      end
      checks++; if ({iss_vld, iss_op, iss_src1, iss_src2, iss_dst} !== {m_iss_vld, m_iss_op, m_iss_s1, m_iss_s2, m_iss_dst}) begin
        errors++; $display("FAIL rnd_issue cyc=%0d got %b %h %h %h %h required %b %h %h %h %h", c,
                           iss_vld, iss_op, iss_src1, iss_src2, iss_dst,
                           m_iss_vld, m_iss_op, m_iss_s1, m_iss_s2, m_iss_dst);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_full_reuse();
    test_bypass();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_alu_station.md
# rs_alu_station

Reservation station entry array for one ALU pipe. Holds dispatched instructions until both source operands are available and snoops the common data bus (CDB) for results. Presents a per-entry ready vector to `rs_issue_unit` and takes back that unit's single selection. Drives the selected entry's operands into a registered issue stage feeding the ALU.

## Interface

- `RS_ENT_NUM`, 2: number of entries.
- `RS_ENT_SEL`, 1: entry index width, equal to clog2(`RS_ENT_NUM`).
- `DATA_W`, 32: operand width.
- `TAG_W`, 6: ROB tag width.
- `OP_W`, 4: ALU opcode width.

- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_flush` in 1: synchronous kill of all entries and the issue register.
- `i_dsp_vld` in 1: dispatch request.
- `i_dsp_op` in `OP_W`: opcode.
- `i_dsp_src1_rdy` in 1: src1 value is present in `i_dsp_src1_data`.
- `i_dsp_src1_data` in `DATA_W`: src1 value.
- `i_dsp_src1_tag` in `TAG_W`: src1 producer tag, used when not ready.
- `i_dsp_src2_rdy`, `i_dsp_src2_data`, `i_dsp_src2_tag`: same as src1.
- `i_dsp_dst_tag` in `TAG_W`: destination ROB tag.
- `o_full` out 1: no free entry; dispatch is accepted only when `i_dsp_vld & ~o_full`.
- `i_cdb_vld` in 1: result broadcast.
- `i_cdb_tag` in `TAG_W`: broadcast tag.
- `i_cdb_data` in `DATA_W`: broadcast value.
- `o_rdy_vec` out `RS_ENT_NUM`: entry valid and both sources ready; connects to issue unit `i_vld_vec`.
- `i_sel_vld` in 1: issue unit grant valid.
- `i_sel` in `RS_ENT_SEL`: granted entry index.
- `o_iss_vld` out 1: issue register valid.
- `o_iss_op` out `OP_W`: issued opcode.
- `o_iss_src1` out `DATA_W`: issued src1 value.
- `o_iss_src2` out `DATA_W`: issued src2 value.
- `o_iss_dst_tag` out `TAG_W`: issued destination tag.

## Operation

- Per-entry state: `vld`, `op`, `s1_rdy`, `s1_data`, `s1_tag`, `s2_rdy`, `s2_data`, `s2_tag`, `dst_tag`.
- **Allocate**
  - On an accepted dispatch, write the lowest-index entry with `vld=0`.
  - The free search uses current-cycle `vld`. An entry freed by issue this cycle is not reusable until the next cycle.
- **Dispatch bypass**
  - If a dispatched source is not ready and `i_cdb_vld` is high with `i_cdb_tag` equal to its tag in the same cycle, write the entry with that source ready and holding `i_cdb_data`.
- **Wakeup**
  - For every valid entry, for each source with `rdy=0` and a tag match on a valid CDB: set `rdy=1` and capture the data.
  - src1 and src2 are matched independently; both may wake on one broadcast.
- **Ready vector**
  - `o_rdy_vec[k] = vld & s1_rdy & s2_rdy`, computed from registered state only. A woken entry therefore shows ready the cycle after the broadcast.
- **Issue**
  - When `i_sel_vld` is high and `o_rdy_vec[i_sel]` is high: load the entry's fields into the issue register, set `o_iss_vld=1`, and clear the entry's `vld`.
  - When `i_sel_vld` is low, or the selected entry is not ready: `o_iss_vld=0` next cycle and the entry is untouched.
- **`o_full`**: AND of all entry `vld` bits, from registered state.
- **Flush**
  - Next edge: all `vld=0` and `o_iss_vld=0`.
  - Flush overrides a same-cycle dispatch, wakeup and issue.
- The ALU always accepts; there is no backpressure on the issue register.

## Timing

- Reset state, all outputs: `o_full=0`, `o_rdy_vec=0`, `o_iss_vld=0`, `o_iss_op=0`, `o_iss_src1=0`, `o_iss_src2=0`, `o_iss_dst_tag=0`; all entry fields are 0.
- Reset is asynchronous on assert and clears everything, including any mid-issue data.
- Dispatch with both sources ready at edge N:
  - `o_rdy_vec` bit is high in cycle N+1.
  - With the grant in N+1, `o_iss_vld` is high in cycle N+2.
- CDB wakeup at edge N: ready in N+1, earliest issue output in N+2.
- Entry turnover: issued at edge N, so `vld` is low in N+1. `o_full` drops in N+1 and the entry can be reallocated at edge N+1.
- Dispatch and issue of different entries in the same cycle are both honoured.
- The issue register holds for exactly one cycle per grant; back-to-back grants give continuous `o_iss_vld`.

## Test plan

- **Reset:** assert `i_rst_n=0` mid-cycle -> all outputs 0 immediately; after release, `o_full=0`.
- **Ready dispatch:** dispatch op=3, src1=0x11, src2=0x22 (both ready), dst=5, and grant entry 0 in the next cycle -> `o_iss_vld=1`, op=3, src1=0x11, src2=0x22, dst_tag=5 two cycles after dispatch.
- **Wakeup:** dispatch src1 waiting on tag 9 -> `o_rdy_vec=0`. CDB tag 9, data 0xAB -> `o_rdy_vec[0]=1` next cycle and issued src1=0xAB. A CDB with tag 8 causes no wakeup.
- **Full and reuse:** fill both entries -> `o_full=1`, and a third dispatch is ignored. Issue entry 1 -> `o_full=0` one cycle later, and the next dispatch lands in entry 1.
- **Dispatch bypass:** dispatch src2 waiting on tag 4 while the CDB broadcasts tag 4, data 0x77 -> entry ready in the next cycle with src2=0x77.
- **Flush:** two valid entries plus a pending grant, then `i_flush=1` -> next cycle `o_rdy_vec=0`, `o_iss_vld=0`, `o_full=0`, and a same-cycle dispatch is dropped.
